mod_mul_seq: RTL and testbench

Sequential modular multiplier computing c = (a·b) mod q over 23-bit coefficients with an MSB-first interleaved shift-add-reduce loop, one multiplier bit per clock. It sits directly upstream of the modular adder in the PE datapath, and its c_o drives the adder's b_i operand. Valid/ready handshakes on both sides let the PE controller stall it.

---
 rtl/pe_pkg.sv | 15 +
 rtl/mod_mul_seq_if.sv | 42 ++++
 rtl/mod_mul_step.sv | 34 +++
 rtl/mod_mul_seq.sv | 101 ++++++++++
 tb/tb_mod_mul_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared PE datapath definitions: coefficient width, Dilithium modulus and
// the modular-multiplier FSM state encoding.
package pe_pkg;

  localparam int COEF_W = 23;
  localparam int CNT_W  = 5;
  localparam logic [COEF_W-1:0] Q_DIL = 23'd8380417;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mod_mul_state_t;

endpackage

// File: rtl/mod_mul_seq_if.sv
// Operand/result handshake bundle for mod_mul_seq. out_err_o only exists
// when MOD_MUL_RANGE_CHK_EN is defined.
interface mod_mul_seq_if;
  import pe_pkg::*;

  // Both sides use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid, once raised, holds its payload
  // stable until that edge, and ready never depends combinationally on valid.
  logic              in_valid_i;
  logic              in_ready_o;
  logic [COEF_W-1:0] a_i;
  logic [COEF_W-1:0] b_i;
  logic [COEF_W-1:0] q_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [COEF_W-1:0] c_o;
  mod_mul_state_t    dbg_state;
`ifdef MOD_MUL_RANGE_CHK_EN
  logic              out_err_o;

  modport master (
    output in_valid_i, a_i, b_i, q_i, out_ready_i,
    input  in_ready_o, out_valid_o, c_o, dbg_state, out_err_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, q_i, out_ready_i,
    output in_ready_o, out_valid_o, c_o, dbg_state, out_err_o
  );
`else
  modport master (
    output in_valid_i, a_i, b_i, q_i, out_ready_i,
    input  in_ready_o, out_valid_o, c_o, dbg_state
  );

  modport slave (
    input  in_valid_i, a_i, b_i, q_i, out_ready_i,
    output in_ready_o, out_valid_o, c_o, dbg_state
  );
`endif

endinterface

// File: rtl/mod_mul_step.sv
// One interleaved multiply step: acc_next = (2*acc + (b_bit ? a : 0)) mod q,
// assuming acc < q and a < q so at most 2q has to be removed.
module mod_mul_step
  import pe_pkg::*;
(
  input  logic [COEF_W-1:0] acc,
  input  logic [COEF_W-1:0] a,
  input  logic              b_bit,
  input  logic [COEF_W-1:0] q,
  output logic [COEF_W-1:0] acc_next
);

  localparam int TW = COEF_W + 2;

  logic [TW-1:0]     t;
  logic [TW-1:0]     q1;
  logic [TW-1:0]     q2;
  logic [COEF_W-1:0] sub;

  always_comb begin
    q1  = {2'b00, q};
    q2  = {1'b0, q, 1'b0};
    t   = {1'b0, acc, 1'b0} + (b_bit ? {2'b00, a} : '0);
    sub = '0;
    if (t >= q2) begin
      sub = {q[COEF_W-2:0], 1'b0};
    end else if (t >= q1) begin
      sub = q;
    end
    // The reduced value is below q < 2^COEF_W, so the low bits alone are exact.
    acc_next = t[COEF_W-1:0] - sub;
  end

endmodule

// File: rtl/mod_mul_seq.sv
// Sequential MSB-first modular multiplier c = (a*b) mod q, one multiplier
// bit per clock. Optional operand range check under MOD_MUL_RANGE_CHK_EN.
module mod_mul_seq
  import pe_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  mod_mul_seq_if.slave bus
);

  mod_mul_state_t    state;
  mod_mul_state_t    state_next;
  logic [COEF_W-1:0] a_q;
  logic [COEF_W-1:0] b_q;
  logic [COEF_W-1:0] q_q;
  logic [COEF_W-1:0] acc;
  logic [COEF_W-1:0] acc_next;
  logic [COEF_W-1:0] c_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              last_step;
`ifdef MOD_MUL_RANGE_CHK_EN
  logic              err_q;
`endif

  assign accept    = (state == IDLE) && bus.in_valid_i;
  assign last_step = (state == RUN) && (cnt == '0);

  mod_mul_step u_step (
    .acc      (acc),
    .a        (a_q),
    .b_bit    (b_q[cnt]),
    .q        (q_q),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid_i) state_next = RUN;
      RUN:     if (cnt == '0) state_next = DONE;
      DONE:    if (bus.out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      q_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      c_q   <= '0;
`ifdef MOD_MUL_RANGE_CHK_EN
      err_q <= 1'b0;
`endif
    end else if (accept) begin
      a_q   <= bus.a_i;
      b_q   <= bus.b_i;
      q_q   <= bus.q_i;
      acc   <= '0;
      cnt   <= CNT_W'(COEF_W - 1);
`ifdef MOD_MUL_RANGE_CHK_EN
      err_q <= (bus.a_i >= bus.q_i) | (bus.b_i >= bus.q_i) | (bus.q_i < COEF_W'(3));
`endif
    end else if (state == RUN) begin
      acc <= acc_next;
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Result register only moves on entry to DONE so c_o survives the handshake.
      if (last_step) begin
`ifdef MOD_MUL_RANGE_CHK_EN
        c_q <= err_q ? '0 : acc_next;
`else
        c_q <= acc_next;
`endif
      end
    end
  end

  always_comb begin
    bus.in_ready_o  = (state == IDLE);
    bus.out_valid_o = (state == DONE);
    bus.c_o         = c_q;
    bus.dbg_state   = state;
`ifdef MOD_MUL_RANGE_CHK_EN
    bus.out_err_o   = (state == DONE) && err_q;
`endif
  end

endmodule

// File: tb/tb_mod_mul_seq.sv
// Directed bench for mod_mul_seq: hand-computed products, latency, backpressure,
// mid-run reset and (with MOD_MUL_RANGE_CHK_EN) the range-error path.
module tb_mod_mul_seq;
  import pe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_mul_seq_if bus();

  mod_mul_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [COEF_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [COEF_W-1:0] a, input logic [COEF_W-1:0] b,
                       input logic [COEF_W-1:0] q, input logic [COEF_W-1:0] exp);
    check({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
    bus.in_valid_i = 1'b1;
    bus.a_i = a;
    bus.b_i = b;
    bus.q_i = q;
    tick();
    bus.in_valid_i = 1'b0;
    exp_q.push_back(exp);
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!bus.out_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd23);
  endtask

  task automatic take_result(input string tag);
    logic [COEF_W-1:0] exp;
    exp = '0;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
    check({tag, "_c"}, 32'(bus.c_o), 32'(exp));
`ifdef MOD_MUL_RANGE_CHK_EN
    check({tag, "_err"}, 32'(bus.out_err_o), 32'd0);
`endif
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.out_valid_o), 32'd0);
    check({tag, "_c_kept"}, 32'(bus.c_o), 32'(exp));
  endtask

  task automatic op(input string tag, input logic [COEF_W-1:0] a, input logic [COEF_W-1:0] b,
                    input logic [COEF_W-1:0] q, input logic [COEF_W-1:0] exp);
    issue(tag, a, b, q, exp);
    wait_done(tag);
    take_result(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [COEF_W-1:0] ra, rb, rq;
    logic [63:0] ref_v;

    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.q_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_c", 32'(bus.c_o), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
`ifdef MOD_MUL_RANGE_CHK_EN
    check("rst_err", 32'(bus.out_err_o), 32'd0);
`endif

    // Directed vectors, expected values worked out by hand.
    op("small",     23'd2,       23'd3,       Q_DIL, 23'd6);
    op("qm1_sq",    23'd8380416, 23'd8380416, Q_DIL, 23'd1);
    op("half_x2",   23'd4190209, 23'd2,       Q_DIL, 23'd1);
    op("zero_a",    23'd0,       23'd8380416, Q_DIL, 23'd0);
    op("one_b",     23'd8380416, 23'd1,       Q_DIL, 23'd8380416);
    op("qm1_x2",    23'd8380416, 23'd2,       Q_DIL, 23'd8380415);
    op("pow2",      23'd4096,    23'd4096,    Q_DIL, 23'd16382);
    op("q3",        23'd2,       23'd2,       23'd3, 23'd1);
    op("q7",        23'd5,       23'd6,       23'd7, 23'd2);

    // Backpressure: DONE held, new operands refused.
    issue("bp", 23'd1000, 23'd1000, Q_DIL, 23'd1000000);
    wait_done("bp");
    for (int i = 0; i < 10; i++) begin
      bus.in_valid_i = 1'b1;
      bus.a_i = 23'd5;
      bus.b_i = 23'd5;
      bus.q_i = Q_DIL;
      check("bp_c_hold", 32'(bus.c_o), 32'd1000000);
      check("bp_valid_hold", 32'(bus.out_valid_o), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
      tick();
    end
    bus.in_valid_i = 1'b0;
    take_result("bp");
    check("bp_idle", 32'(bus.dbg_state), 32'(IDLE));
    op("after_bp",  23'd7,       23'd9,       Q_DIL, 23'd63);

    // Reset on the 10th RUN cycle discards the operation.
    bus.in_valid_i = 1'b1;
    bus.a_i = 23'd123;
    bus.b_i = 23'd456;
    bus.q_i = Q_DIL;
    tick();
    bus.in_valid_i = 1'b0;
    repeat (9) tick();
    check("mid_run_state", 32'(bus.dbg_state), 32'(RUN));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("mrst_c", 32'(bus.c_o), 32'd0);
    repeat (30) tick();
    check("mrst_no_output", 32'(bus.out_valid_o), 32'd0);
    op("after_rst", 23'd123,     23'd456,     Q_DIL, 23'd56088);

    // Reset wins over a simultaneous in_valid.
    rst = 1'b1;
    bus.in_valid_i = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid_i = 1'b0;
    tick();
    check("rst_vs_valid", 32'(bus.dbg_state), 32'(IDLE));

`ifdef MOD_MUL_RANGE_CHK_EN
    issue("err_a_eq_q", Q_DIL, 23'd5, Q_DIL, 23'd0);
    wait_done("err_a_eq_q");
    check("err_flag", 32'(bus.out_err_o), 32'd1);
    check("err_c", 32'(bus.c_o), 32'd0);
    void'(exp_q.pop_front());
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check("err_clear", 32'(bus.out_err_o), 32'd0);
`endif

    // Random operands against a 64-bit reference product.
    for (int i = 0; i < 200; i++) begin
      if (i < 150) rq = Q_DIL;
      else rq = COEF_W'($urandom_range(3, 8388607)) | 23'd1;
      ra = COEF_W'($urandom_range(0, 32'(rq) - 1));
      rb = COEF_W'($urandom_range(0, 32'(rq) - 1));
      ref_v = (64'(ra) * 64'(rb)) % 64'(rq);
      op("rand", ra, rb, rq, ref_v[COEF_W-1:0]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
